// File: rtl/tdm_serialiser.sv
`default_nettype none
// ============================================================================
// Module   : tdm_serialiser
// Purpose  : Multi-channel TDM frame serialiser with one-frame holding buffer,
//            clk_en-gated bit shifting and configurable frame-sync marker.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_serialiser #(
  parameter int NUM_BITS  = 24,
  parameter int NUM_CH    = 2,
  parameter int MSB_FIRST = 1,
  parameter int SYNC_MODE = 0,
  localparam int FRAME_BITS = NUM_CH * NUM_BITS,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FRAME_BITS-1:0] s_data,
  output logic                  serial_out,
  output logic                  frame_sync,
  output logic [CH_W-1:0]       ch_idx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BC_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [BC_W-1:0] C_LAST_BIT = BC_W'(NUM_BITS - 1);
  localparam logic [CH_W-1:0] C_LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_hold_full;
  logic [FRAME_BITS-1:0] r_hold_data;
  logic [FRAME_BITS-1:0] r_shift_data;
  logic [BC_W-1:0]       r_bit_cnt;
  logic [CH_W-1:0]       r_ch_cnt;
  logic                  r_frame_done;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_frame_end;
  logic                  w_last;
  logic                  w_first;
  logic                  w_sync;
  logic [NUM_BITS-1:0]   w_word;
  logic [BC_W-1:0]       w_bit_sel;

  // The holding register is the only path into the shifter; no bypass.
  assign w_accept = s_valid & ~r_hold_full;
  assign w_last   = (r_bit_cnt == C_LAST_BIT) && (r_ch_cnt == C_LAST_CH);
  assign w_first  = (r_bit_cnt == '0) && (r_ch_cnt == '0);

  assign s_ready    = ~r_hold_full;
  assign ch_idx     = r_ch_cnt;
  assign frame_done = r_frame_done;

  // Channel word selection from the frame currently on the wire.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch_cnt == CH_W'(k)) begin
        w_word = r_shift_data[k*NUM_BITS +: NUM_BITS];
      end
    end
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_bit_sel = C_LAST_BIT - r_bit_cnt;
    end else begin : g_lsb_first
      assign w_bit_sel = r_bit_cnt;
    end

    if (SYNC_MODE != 0) begin : g_sync_first_bit
      assign w_sync = w_first;
    end else begin : g_sync_whole_frame
      assign w_sync = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_frame_end = 1'b0;
    serial_out  = 1'b0;
    frame_sync  = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clk_en && r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        serial_out = w_word[w_bit_sel];
        frame_sync = w_sync;
        busy       = 1'b1;
        // Back-to-back reload on the edge that ends the final bit period.
        if (clk_en && w_last) begin
          w_frame_end = 1'b1;
          if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= s_data;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_data <= '0;
      r_bit_cnt    <= '0;
      r_ch_cnt     <= '0;
    end else if (w_load) begin
      r_shift_data <= r_hold_data;
      r_bit_cnt    <= '0;
      r_ch_cnt     <= '0;
    end else if (clk_en && (r_state == ST_SHIFT)) begin
      if (w_frame_end) begin
        r_bit_cnt <= '0;
        r_ch_cnt  <= '0;
      end else if (r_bit_cnt == C_LAST_BIT) begin
        r_bit_cnt <= '0;
        r_ch_cnt  <= r_ch_cnt + 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_serialiser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tdm_serialiser
// Purpose  : Scoreboard bench for two tdm_serialiser configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_serialiser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic [1:0]  sv;
  logic [15:0] sd [2];
  logic [1:0]  so, fs, bz, fd, rdy;
  logic [0:0]  ch0;
  logic [1:0]  ch1;
  int          ce_mode = 0;
  int          ce_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic b;
    int   ch;
    logic sync;
    logic last;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        mon_e;
  logic        pend [2];
  int          busy_run [2];
  int          last_run [2];
  logic        prev_so [2];
  logic        prev_bz [2];
  logic        ce_s, r_s;
  logic [1:0]  chv;

  always #5 clk = ~clk;

  tdm_serialiser #(.NUM_BITS(8), .NUM_CH(2), .MSB_FIRST(1), .SYNC_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .s_valid(sv[0]), .s_ready(rdy[0]),
    .s_data(sd[0]), .serial_out(so[0]), .frame_sync(fs[0]), .ch_idx(ch0),
    .busy(bz[0]), .frame_done(fd[0]));

  tdm_serialiser #(.NUM_BITS(4), .NUM_CH(4), .MSB_FIRST(0), .SYNC_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .s_valid(sv[1]), .s_ready(rdy[1]),
    .s_data(sd[1]), .serial_out(so[1]), .frame_sync(fs[1]), .ch_idx(ch1),
    .busy(bz[1]), .frame_done(fd[1]));

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Expected bit stream of a frame, built directly from the channel words.
  function automatic void model_push(int d, logic [15:0] data);
    int   nb  = (d == 0) ? 8 : 4;
    int   nc  = (d == 0) ? 2 : 4;
    bit   msb = (d == 0);
    bit   sm  = (d == 1);
    exp_t e;
    for (int c = 0; c < nc; c++) begin
      for (int i = 0; i < nb; i++) begin
        int pos = msb ? (nb - 1 - i) : i;
        e.b    = data[c*nb + pos];
        e.ch   = c;
        e.sync = sm ? ((c == 0) && (i == 0)) : 1'b1;
        e.last = (c == nc - 1) && (i == nb - 1);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  always @(negedge clk) begin
    ce_cnt = ce_cnt + 1;
    if (ce_mode == 0) clk_en = ((ce_cnt % 4) == 0);
    else              clk_en = ($urandom_range(0, 2) == 0);
  end

  // Monitor: compares each presented bit against the scoreboard queues.
  always begin
    @(posedge clk);
    ce_s = clk_en;
    r_s  = rst;
    #1;
    for (int d = 0; d < 2; d++) begin
      chv = (d == 0) ? {1'b0, ch0} : ch1;
      if (r_s) begin
        if (d == 0) q0.delete(); else q1.delete();
        pend[d]     = 1'b0;
        busy_run[d] = 0;
        chk("rst_serial", d, so[d], 0);
        chk("rst_sync", d, fs[d], 0);
        chk("rst_busy", d, bz[d], 0);
        chk("rst_ready", d, rdy[d], 1);
        chk("rst_done", d, fd[d], 0);
        chk("rst_ch", d, chv, 0);
      end else begin
        chk("frame_done", d, fd[d], {31'd0, ce_s && pend[d]});
        if (!ce_s) begin
          chk("hold_serial", d, so[d], prev_so[d]);
          chk("hold_busy", d, bz[d], prev_bz[d]);
        end else begin
          pend[d] = 1'b0;
          if (bz[d]) begin
            if (qsize(d) == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_bit dut%0d: actual=busy required=idle at %0t", d, $time);
            end else begin
              mon_e = qpop(d);
              chk("serial_out", d, so[d], mon_e.b);
              chk("ch_idx", d, chv, mon_e.ch);
              chk("frame_sync", d, fs[d], mon_e.sync);
              if (mon_e.last) pend[d] = 1'b1;
              busy_run[d]++;
            end
          end else begin
            chk("idle_serial", d, so[d], 0);
            chk("idle_sync", d, fs[d], 0);
            if (busy_run[d] > 0) last_run[d] = busy_run[d];
            busy_run[d] = 0;
          end
        end
      end
      prev_so[d] = so[d];
      prev_bz[d] = bz[d];
    end
  end

  task automatic send(int d, logic [15:0] data);
    int n = 0;
    @(negedge clk);
    sv[d] = 1'b1;
    sd[d] = data;
    while (!rdy[d]) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        chk("send_timeout", d, 0, 1);
        sv[d] = 1'b0;
        return;
      end
    end
    model_push(d, data);
    @(negedge clk);
    sv[d] = 1'b0;
  endtask

  task automatic wait_ticks(int n);
    repeat (n) @(posedge clk iff clk_en);
    #2;
  endtask

  task automatic wait_idle(int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bz[d] || !rdy[d] || qsize(d) != 0 || pend[d]) && n < 3000);
    if (n >= 3000) chk("idle_timeout", d, 0, 1);
  endtask

  initial begin
    int n;
    sv = 2'b00;
    sd[0] = '0;
    sd[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chv = (d == 0) ? {1'b0, ch0} : ch1;
      chk("init_ready", d, rdy[d], 1);
      chk("init_serial", d, so[d], 0);
      chk("init_sync", d, fs[d], 0);
      chk("init_busy", d, bz[d], 0);
      chk("init_done", d, fd[d], 0);
      chk("init_ch", d, chv, 0);
    end

    send(0, 16'hA55A);
    wait_idle(0);
    chk("single_run", 0, last_run[0], 16);

    send(1, 16'h0180);
    wait_idle(1);
    chk("single_run", 1, last_run[1], 16);

    send(0, 16'h1234);
    send(0, 16'hFFFF);
    chk("ready_low_held", 0, rdy[0], 0);
    wait_idle(0);
    chk("b2b_run", 0, last_run[0], 32);

    // Reset mid-frame with a second frame waiting in the holding register.
    send(0, 16'hC3C3);
    send(0, 16'h5A5A);
    wait_ticks(4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 0, bz[0], 0);
    chk("mid_rst_ready", 0, rdy[0], 1);
    chk("mid_rst_serial", 0, so[0], 0);
    chk("mid_rst_done", 0, fd[0], 0);
    repeat (300) @(negedge clk);
    chk("held_discarded", 0, bz[0], 0);

    // Offer a frame on the same edge as a clk_en tick while idle.
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!clk_en && n < 100);
    sv[0] = 1'b1;
    sd[0] = 16'h6C93;
    model_push(0, 16'h6C93);
    @(posedge clk);
    #2;
    chk("no_load_same_edge", 0, bz[0], 0);
    chk("ready_drop", 0, rdy[0], 0);
    @(negedge clk);
    sv[0] = 1'b0;
    wait_ticks(1);
    chk("load_next_tick", 0, bz[0], 1);
    chk("ready_back", 0, rdy[0], 1);
    wait_idle(0);

    ce_mode = 1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 40)) @(negedge clk);
          send(0, 16'($urandom));
        end
      end
      begin
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 40)) @(negedge clk);
          send(1, 16'($urandom));
        end
      end
    join
    wait_idle(0);
    wait_idle(1);
    chk("final_q0_empty", 0, qsize(0), 0);
    chk("final_q1_empty", 1, qsize(1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tdm_serialiser.md
Name: tdm_serialiser

Overview:
- Parametrised multi-channel frame serialiser for the codec/DAC output path; successor to the single-word 24-bit shifter.
- Accepts one frame of NUM_CH packed channel words over a valid/ready handshake and buffers one further frame in a holding register.
- Shifts the frame out one bit per clk_en tick, channel 0 first, with a frame-sync output and back-to-back frames when data is waiting.

Parameters:
- NUM_BITS, 24, bits per channel word (>=2)
- NUM_CH, 2, channels per frame (>=1)
- MSB_FIRST, 1, 1 = each channel word sent MSB first; 0 = LSB first
- SYNC_MODE, 0, 0 = frame_sync high for every bit of the frame; 1 = frame_sync high only during the first bit of the frame
- Derived: FRAME_BITS = NUM_CH*NUM_BITS; CH_W = max(1, clog2(NUM_CH))

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  bit-rate tick, one clk cycle wide; all shifting is gated by it
- s_valid  in  1  frame offered
- s_ready  out  1  holding register empty; frame accepted on clk edge with s_valid&&s_ready
- s_data  in  FRAME_BITS  channel k in s_data[k*NUM_BITS +: NUM_BITS]
- serial_out  out  1  current serial bit
- frame_sync  out  1  frame marker per SYNC_MODE
- ch_idx  out  CH_W  channel currently presented on serial_out
- busy  out  1  shifter is transmitting a frame
- frame_done  out  1  one-clk pulse when the last bit period of a frame ends

Behaviour:
- Reset (any time, including mid-frame): the shifter and holding register are cleared and any held frame is discarded. Outputs after reset: s_ready=1, serial_out=0, frame_sync=0, ch_idx=0, busy=0, frame_done=0.
- Holding register:
  - Written on any clk edge with s_valid&&s_ready; clk_en is not required.
  - s_ready = !hold_full, registered, so it drops the cycle after accept.
  - Emptied only when the shifter loads from it.
  - No bypass path: a frame always passes through the holding register.
- States: IDLE, SHIFT.
- IDLE:
  - Outputs: serial_out=0, frame_sync=0, busy=0.
  - On a clk_en edge with hold_full=1: load the shifter, clear hold_full, set bit_cnt=0, ch_cnt=0, enter SHIFT.
  - The first bit appears on serial_out immediately after that edge.
- Latency: a frame accepted at edge E loads on the first clk_en edge strictly after E.
- SHIFT, bit presentation:
  - Each clk_en edge advances one bit.
  - serial_out shows channel ch_cnt, bit (NUM_BITS-1-bit_cnt) if MSB_FIRST, else bit bit_cnt.
  - ch_idx = ch_cnt.
  - busy = 1.
- SHIFT, frame_sync:
  - SYNC_MODE 0: high throughout SHIFT.
  - SYNC_MODE 1: high only while ch_cnt=0 and bit_cnt=0.
- Counter wrap:
  - bit_cnt wraps NUM_BITS-1 -> 0 and increments ch_cnt.
  - After the final bit (ch_cnt=NUM_CH-1, bit_cnt=NUM_BITS-1), the next clk_en edge pulses frame_done for exactly one clk.
  - On that same edge: if hold_full=1, reload immediately (no gap bit, frame_sync reasserts, s_ready rises next cycle); otherwise return to IDLE.
- Between clk_en ticks all outputs hold.
- s_valid while s_ready=0: ignored, and the source must hold it.
- A new frame accepted during SHIFT waits in the holding register. The frame currently on the wire is never modified.
- NUM_CH=1: ch_idx is constant 0 and the frame is a single word.

Test Plan:
- NUM_BITS=8, NUM_CH=2, MSB_FIRST=1, SYNC_MODE=0, clk_en every 4 clk; send s_data=16'hA55A -> serial_out bits 0,1,0,1,1,0,1,0 (ch0=5A) then 1,0,1,0,0,1,0,1 (ch1=A5); ch_idx 0 for 8 ticks then 1; frame_sync high 16 ticks; single frame_done; then IDLE.
- Same config, MSB_FIRST=0, s_data=16'h0180 -> ch0 (80) LSB-first gives 0000_0001, ch1 (01) gives 1000_0000.
- Two frames 16'h1234 and 16'hFFFF offered back-to-back -> second accepted during shifting; s_ready low until reload; 32 contiguous bit ticks with no idle gap; two frame_done pulses spaced 16 ticks apart.
- SYNC_MODE=1, NUM_CH=4, NUM_BITS=4, one frame -> frame_sync high for tick 0 only; ch_idx sequence 0,1,2,3 each for 4 ticks.
- Assert rst at tick 5 of a frame with a second frame held -> next cycle: serial_out=0, busy=0, s_ready=1, no frame_done; the held frame is never transmitted.
- s_valid asserted in the same cycle as clk_en while IDLE -> frame loads on the following clk_en, not the current one; s_ready toggles 1->0->1 around the load.
